// File: rtl/alu_writeback_ctrl.sv
// Read-execute-writeback sequencer and ALU in front of the 8x3 register bank.
// It accepts one instruction per four cycles and retires it through the bank's single write port.
module alu_writeback_ctrl #(
  parameter int N = 3,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [2:0]   instr_op,
  input  logic [N-1:0] instr_rs1,
  input  logic [N-1:0] instr_rs2,
  input  logic [N-1:0] instr_rd,
  input  logic [W-1:0] instr_imm,
  output logic [N-1:0] addr_rs1,
  output logic [N-1:0] addr_rs2,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic         we,
  output logic [N-1:0] addr_rd,
  output logic [W-1:0] data_in,
  output logic         done,
  output logic         flag_zero,
  output logic         flag_carry
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_LI  = 3'b111;

  state_t       state;
  logic [2:0]   op_q;
  logic [N-1:0] rd_q;
  logic [W-1:0] imm_q;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  logic [W:0]   alu_res;
  logic         alu_carry;
  logic         big_shift;

  assign instr_ready = (state == IDLE);
  assign big_shift   = (32'(op_b) >= W);

  // Result is formed one bit wider so the ADD carry falls out of the top bit.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = {1'b0, op_a} + {1'b0, op_b};
        alu_carry = alu_res[W];
      end
      OP_SUB: begin
        alu_res   = {1'b0, op_a} - {1'b0, op_b};
        alu_carry = (op_a < op_b);
      end
      OP_AND: alu_res = {1'b0, op_a & op_b};
      OP_OR:  alu_res = {1'b0, op_a | op_b};
      OP_XOR: alu_res = {1'b0, op_a ^ op_b};
      OP_SLL: alu_res = big_shift ? '0 : {1'b0, op_a << op_b};
      OP_SRL: alu_res = big_shift ? '0 : {1'b0, op_a >> op_b};
      OP_LI:  alu_res = {1'b0, imm_q};
      default: alu_res = '0;
    endcase
  end

  // Read addresses, write address/data and flags all hold between their update points.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      addr_rs1   <= '0;
      addr_rs2   <= '0;
      we         <= 1'b0;
      addr_rd    <= '0;
      data_in    <= '0;
      done       <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q     <= instr_op;
            rd_q     <= instr_rd;
            imm_q    <= instr_imm;
            addr_rs1 <= instr_rs1;
            addr_rs2 <= instr_rs2;
            state    <= READ;
          end
        end
        READ: begin
          op_a  <= rs1;
          op_b  <= rs2;
          state <= EXEC;
        end
        EXEC: begin
          data_in    <= alu_res[W-1:0];
          flag_zero  <= (alu_res[W-1:0] == '0);
          flag_carry <= alu_carry;
          addr_rd    <= rd_q;
          // Register 0 is hardwired to zero, so its write is dropped but still retired.
          we         <= (rd_q != '0);
          done       <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          we    <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Directed bench for alu_writeback_ctrl, closing the loop through a behavioural 8x3 register bank.
module tb_alu_writeback_ctrl;

  localparam int N = 3;
  localparam int W = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_LI  = 3'b111;

  logic         clk;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   instr_op;
  logic [N-1:0] instr_rs1;
  logic [N-1:0] instr_rs2;
  logic [N-1:0] instr_rd;
  logic [W-1:0] instr_imm;
  logic [N-1:0] addr_rs1;
  logic [N-1:0] addr_rs2;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         we;
  logic [N-1:0] addr_rd;
  logic [W-1:0] data_in;
  logic         done;
  logic         flag_zero;
  logic         flag_carry;

  logic [W-1:0] regs [2**N];
  int compare_count = 0;
  int fail_count    = 0;
  int done_seen;

  alu_writeback_ctrl #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_rs1  (instr_rs1),
    .instr_rs2  (instr_rs2),
    .instr_rd   (instr_rd),
    .instr_imm  (instr_imm),
    .addr_rs1   (addr_rs1),
    .addr_rs2   (addr_rs2),
    .rs1        (rs1),
    .rs2        (rs2),
    .we         (we),
    .addr_rd    (addr_rd),
    .data_in    (data_in),
    .done       (done),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank: one write port, two combinational read ports, register 0 reads zero.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**N; i++) regs[i] <= '0;
    end else if (we) begin
      regs[addr_rd] <= data_in;
    end
  end

  assign rs1 = (addr_rs1 == '0) ? '0 : regs[addr_rs1];
  assign rs2 = (addr_rs2 == '0) ? '0 : regs[addr_rs2];

  function automatic logic [W-1:0] bank_read(input logic [N-1:0] a);
    return (a == '0) ? '0 : regs[a];
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Issues one instruction from an idle DUT and follows it cycle by cycle to retirement.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [N-1:0] a1,
                               input logic [N-1:0] a2, input logic [N-1:0] rd, input logic [W-1:0] imm,
                               input logic [W-1:0] exp_res, input logic exp_zero, input logic exp_carry);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rs1   = a1;
    instr_rs2   = a2;
    instr_rd    = rd;
    instr_imm   = imm;
    checkOutput({tag, " ready"}, 8'(instr_ready), 8'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput({tag, " we_read"}, 8'(we), 8'd0);
    @(negedge clk);
    checkOutput({tag, " we_exec"}, 8'(we), 8'd0);
    @(negedge clk);
    checkOutput({tag, " done"}, 8'(done), 8'd1);
    checkOutput({tag, " we"}, 8'(we), (rd != '0) ? 8'd1 : 8'd0);
    checkOutput({tag, " addr_rd"}, 8'(addr_rd), 8'(rd));
    checkOutput({tag, " data_in"}, 8'(data_in), 8'(exp_res));
    checkOutput({tag, " flag_zero"}, 8'(flag_zero), 8'(exp_zero));
    checkOutput({tag, " flag_carry"}, 8'(flag_carry), 8'(exp_carry));
    @(negedge clk);
    checkOutput({tag, " done_after"}, 8'(done), 8'd0);
    checkOutput({tag, " we_after"}, 8'(we), 8'd0);
    checkOutput({tag, " reg"}, 8'(bank_read(rd)), (rd == '0) ? 8'd0 : 8'(exp_res));
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    instr_rd    = '0;
    instr_imm   = '0;

    $display("[TB] reset behaviour");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst ready", 8'(instr_ready), 8'd1);
    checkOutput("rst we", 8'(we), 8'd0);
    checkOutput("rst done", 8'(done), 8'd0);
    checkOutput("rst flag_zero", 8'(flag_zero), 8'd0);
    checkOutput("rst flag_carry", 8'(flag_carry), 8'd0);
    checkOutput("rst data_in", 8'(data_in), 8'd0);
    rst = 1'b0;

    // LI r1=5 aborted by reset while in EXEC
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = OP_LI;
    instr_rd    = 3'd1;
    instr_imm   = 3'd5;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort we", 8'(we), 8'd0);
    checkOutput("abort done", 8'(done), 8'd0);
    checkOutput("abort ready", 8'(instr_ready), 8'd1);
    @(negedge clk);
    checkOutput("abort we_later", 8'(we), 8'd0);
    checkOutput("abort done_later", 8'(done), 8'd0);
    checkOutput("abort r1", 8'(bank_read(3'd1)), 8'd0);

    $display("[TB] LI / ADD / SUB");
    applyStimulus("li_r1_5", OP_LI,  3'd0, 3'd0, 3'd1, 3'd5, 3'd5, 1'b0, 1'b0);
    applyStimulus("li_r2_4", OP_LI,  3'd0, 3'd0, 3'd2, 3'd4, 3'd4, 1'b0, 1'b0);
    applyStimulus("add_r3",  OP_ADD, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1);
    applyStimulus("sub_r4",  OP_SUB, 3'd2, 3'd1, 3'd4, 3'd0, 3'd7, 1'b0, 1'b1);
    applyStimulus("sub_r5",  OP_SUB, 3'd1, 3'd1, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0);

    $display("[TB] register zero");
    applyStimulus("li_r0_6", OP_LI,  3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 1'b0, 1'b0);
    applyStimulus("add_r6",  OP_ADD, 3'd0, 3'd2, 3'd6, 3'd0, 3'd4, 1'b0, 1'b0);

    $display("[TB] shifts and logic ops");
    applyStimulus("li_r1_3", OP_LI,  3'd0, 3'd0, 3'd1, 3'd3, 3'd3, 1'b0, 1'b0);
    applyStimulus("li_r2_1", OP_LI,  3'd0, 3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0);
    applyStimulus("li_r3_3", OP_LI,  3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0);
    applyStimulus("sll_r6",  OP_SLL, 3'd1, 3'd2, 3'd6, 3'd0, 3'd6, 1'b0, 1'b0);
    applyStimulus("srl_r7",  OP_SRL, 3'd1, 3'd3, 3'd7, 3'd0, 3'd0, 1'b1, 1'b0);
    applyStimulus("sll_big", OP_SLL, 3'd2, 3'd3, 3'd6, 3'd0, 3'd0, 1'b1, 1'b0);
    applyStimulus("li_r4_5", OP_LI,  3'd0, 3'd0, 3'd4, 3'd5, 3'd5, 1'b0, 1'b0);
    applyStimulus("and_r5",  OP_AND, 3'd4, 3'd1, 3'd5, 3'd0, 3'd1, 1'b0, 1'b0);
    applyStimulus("or_r6",   OP_OR,  3'd4, 3'd1, 3'd6, 3'd0, 3'd7, 1'b0, 1'b0);
    applyStimulus("xor_r7",  OP_XOR, 3'd4, 3'd1, 3'd7, 3'd0, 3'd6, 1'b0, 1'b0);

    $display("[TB] instr_valid held high");
    done_seen = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = OP_ADD;
    instr_rs1   = 3'd1;
    instr_rs2   = 3'd1;
    instr_rd    = 3'd1;
    instr_imm   = 3'd0;
    @(negedge clk);
    checkOutput("hold ready_read", 8'(instr_ready), 8'd0);
    instr_op  = OP_LI;
    instr_rd  = 3'd1;
    instr_imm = 3'd0;
    @(negedge clk);
    checkOutput("hold ready_exec", 8'(instr_ready), 8'd0);
    instr_rd  = 3'd3;
    instr_imm = 3'd2;
    @(negedge clk);
    if (done) done_seen++;
    checkOutput("hold add data_in", 8'(data_in), 8'd6);
    checkOutput("hold ready_write", 8'(instr_ready), 8'd0);
    instr_rd  = 3'd2;
    instr_imm = 3'd2;
    @(negedge clk);
    if (done) done_seen++;
    checkOutput("hold ready_idle", 8'(instr_ready), 8'd1);
    checkOutput("hold r1", 8'(bank_read(3'd1)), 8'd6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) instr_valid = 1'b0;
      if (done) done_seen++;
    end
    checkOutput("hold done_count", 8'(done_seen), 8'd2);
    checkOutput("hold r2", 8'(bank_read(3'd2)), 8'd2);
    checkOutput("hold r3", 8'(bank_read(3'd3)), 8'd3);
    checkOutput("hold r1_final", 8'(bank_read(3'd1)), 8'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
